ibuffer: RTL and testbench

- Instruction buffer between the fetch unit and the decode stage.
- Absorbs fetch bursts of up to 2 instructions per cycle and presents 1 instruction per cycle to decode through ibuffer_instr_valid, ibuffer_inst_out and ibuffer_pc_out.
- Implemented as a circular FIFO with an occupancy counter.
- Supports backpressure from decode and a single-cycle flush on redirect.

---
 rtl/ibuffer.sv | 87 ++++++++
 tb/tb_ibuffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer.sv
// Instruction buffer between fetch and decode: circular FIFO that accepts up to
// two instructions per cycle and presents one head instruction per cycle.
module ibuffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               fetch_valid,
  input  logic [1:0]         fetch_mask,
  input  logic [31:0]        fetch_instr0,
  input  logic [31:0]        fetch_instr1,
  input  logic [47:0]        fetch_pc,
  output logic               fetch_ready,
  input  logic               dec_ready,
  output logic               ibuffer_instr_valid,
  output logic [31:0]        ibuffer_inst_out,
  output logic [47:0]        ibuffer_pc_out,
  output logic [PTR_W:0]     ibuffer_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      instr_mem [DEPTH];
  logic [47:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] tail_plus1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] enq_num;
  logic             not_empty;
  logic             enq;
  logic             deq;
  logic [47:0]      pc_plus4;
  logic [31:0]      slot0_instr;
  logic [47:0]      slot0_pc;

  // Handshakes: flush suppresses both sides in its own cycle.
  assign not_empty           = (count != '0);
  assign fetch_ready         = (count <= CNT_W'(DEPTH - 2)) && !flush;
  assign ibuffer_instr_valid = not_empty && !flush;
  assign enq                 = fetch_valid && fetch_ready;
  assign deq                 = ibuffer_instr_valid && dec_ready;
  assign enq_num             = enq ? (CNT_W'(fetch_mask[0]) + CNT_W'(fetch_mask[1])) : '0;

  // Compaction: the first valid slot always lands at tail, instr1 follows when both valid.
  assign pc_plus4    = fetch_pc + 48'd4;
  assign slot0_instr = fetch_mask[0] ? fetch_instr0 : fetch_instr1;
  assign slot0_pc    = fetch_mask[0] ? fetch_pc : pc_plus4;
  assign tail_plus1  = tail_ptr + PTR_W'(1);

  assign ibuffer_count    = count;
  assign ibuffer_inst_out = not_empty ? instr_mem[head_ptr] : 32'd0;
  assign ibuffer_pc_out   = not_empty ? pc_mem[head_ptr] : 48'd0;

  // Entry storage carries no reset; occupancy gates all reads.
  always_ff @(posedge clock) begin
    if (enq && (fetch_mask != 2'b00)) begin
      instr_mem[tail_ptr] <= slot0_instr;
      pc_mem[tail_ptr]    <= slot0_pc;
    end
    if (enq && (fetch_mask == 2'b11)) begin
      instr_mem[tail_plus1] <= fetch_instr1;
      pc_mem[tail_plus1]    <= pc_plus4;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + PTR_W'(enq_num);
      if (deq) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      count <= count + enq_num - CNT_W'(deq);
    end
  end

endmodule

// File: tb/tb_ibuffer.sv
// Directed self-checking bench for ibuffer: reset, packets, fill/drain wrap,
// concurrent enqueue/dequeue, flush, PC carry wrap and asynchronous reset.
module tb_ibuffer;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        fetch_valid;
  logic [1:0]  fetch_mask;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic [47:0] fetch_pc;
  logic        fetch_ready;
  logic        dec_ready;
  logic        ibuffer_instr_valid;
  logic [31:0] ibuffer_inst_out;
  logic [47:0] ibuffer_pc_out;
  logic [3:0]  ibuffer_count;

  int vectors;
  int miscompares;

  ibuffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_mask(fetch_mask),
    .fetch_instr0(fetch_instr0),
    .fetch_instr1(fetch_instr1),
    .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready),
    .dec_ready(dec_ready),
    .ibuffer_instr_valid(ibuffer_instr_valid),
    .ibuffer_inst_out(ibuffer_inst_out),
    .ibuffer_pc_out(ibuffer_pc_out),
    .ibuffer_count(ibuffer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [47:0] pc, input logic dr);
    fetch_valid  = v;
    fetch_mask   = m;
    fetch_instr0 = i0;
    fetch_instr1 = i1;
    fetch_pc     = pc;
    dec_ready    = dr;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 48'd0, 1'b0);
    #12;
    reset_n = 1'b1;
    step();
    vectors++; if (ibuffer_instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", ibuffer_instr_valid); end
    vectors++; if (fetch_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
    vectors++; if (ibuffer_count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", ibuffer_count); end
    vectors++; if (ibuffer_inst_out !== 32'd0) begin miscompares++; $display("FAIL reset_inst got %h want 0", ibuffer_inst_out); end
    vectors++; if (ibuffer_pc_out !== 48'd0) begin miscompares++; $display("FAIL reset_pc got %h want 0", ibuffer_pc_out); end
  endtask

  task automatic test_one_packet();
    drive(1'b1, 2'b11, 32'h0000_0013, 32'h0010_0093, 48'h8000_0000, 1'b1);
    #1;
    vectors++; if (ibuffer_instr_valid !== 1'b0) begin miscompares++; $display("FAIL pkt_no_bypass got %b want 0", ibuffer_instr_valid); end
    step();
    fetch_valid = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd2) begin miscompares++; $display("FAIL pkt_count2 got %0d want 2", ibuffer_count); end
    vectors++; if (ibuffer_inst_out !== 32'h0000_0013 || ibuffer_pc_out !== 48'h8000_0000 || ibuffer_instr_valid !== 1'b1)
      begin miscompares++; $display("FAIL pkt_head0 got %h@%h v%b want 00000013@80000000 v1", ibuffer_inst_out, ibuffer_pc_out, ibuffer_instr_valid); end
    step();
    vectors++; if (ibuffer_count !== 4'd1) begin miscompares++; $display("FAIL pkt_count1 got %0d want 1", ibuffer_count); end
    vectors++; if (ibuffer_inst_out !== 32'h0010_0093 || ibuffer_pc_out !== 48'h8000_0004)
      begin miscompares++; $display("FAIL pkt_head1 got %h@%h want 00100093@80000004", ibuffer_inst_out, ibuffer_pc_out); end
    step();
    vectors++; if (ibuffer_count !== 4'd0 || ibuffer_instr_valid !== 1'b0)
      begin miscompares++; $display("FAIL pkt_empty got count %0d v%b want 0 v0", ibuffer_count, ibuffer_instr_valid); end
  endtask

  task automatic test_partial();
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'h8000_0020, 1'b0);
    step();
    vectors++; if (ibuffer_count !== 4'd0) begin miscompares++; $display("FAIL mask00_count got %0d want 0", ibuffer_count); end
    drive(1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0020_8133, 48'h8000_0010, 1'b0);
    step();
    fetch_valid = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd1) begin miscompares++; $display("FAIL part_count got %0d want 1", ibuffer_count); end
    vectors++; if (ibuffer_inst_out !== 32'h0020_8133 || ibuffer_pc_out !== 48'h8000_0014)
      begin miscompares++; $display("FAIL part_head got %h@%h want 00208133@80000014", ibuffer_inst_out, ibuffer_pc_out); end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd0) begin miscompares++; $display("FAIL part_drain got %0d want 0", ibuffer_count); end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'b11, 32'hA000 + 32'(2 * k), 32'hA000 + 32'(2 * k + 1),
            48'h9000_0000 + 48'(8 * k), 1'b0);
      #1;
      vectors++; if (fetch_ready !== (k < 4)) begin miscompares++; $display("FAIL fill_ready k%0d got %b want %b", k, fetch_ready, k < 4); end
      step();
    end
    // Packet 4 stays presented while draining; it must never be stored.
    for (int i = 0; i < 8; i++) begin
      fetch_valid = (i < 2);
      dec_ready   = 1'b1;
      #1;
      vectors++; if (ibuffer_count !== 4'(8 - i)) begin miscompares++; $display("FAIL drain_count i%0d got %0d want %0d", i, ibuffer_count, 8 - i); end
      vectors++; if (ibuffer_inst_out !== 32'hA000 + 32'(i) || ibuffer_pc_out !== 48'h9000_0000 + 48'(4 * i))
        begin miscompares++; $display("FAIL drain_head i%0d got %h@%h want %h@%h", i, ibuffer_inst_out, ibuffer_pc_out, 32'hA000 + 32'(i), 48'h9000_0000 + 48'(4 * i)); end
      if (i < 2) begin
        vectors++; if (fetch_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready i%0d got %b want 0", i, fetch_ready); end
      end
      step();
    end
    fetch_valid = 1'b0;
    dec_ready = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd0 || ibuffer_instr_valid !== 1'b0)
      begin miscompares++; $display("FAIL drain_empty got %0d v%b want 0 v0", ibuffer_count, ibuffer_instr_valid); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b11, 32'hB0, 32'hB1, 48'hB000_0000, 1'b0);
    step();
    drive(1'b1, 2'b01, 32'hB2, 32'hFFFF_0000, 48'hB000_0008, 1'b0);
    step();
    drive(1'b1, 2'b11, 32'hB3, 32'hB4, 48'hB000_000C, 1'b1);
    #1;
    vectors++; if (ibuffer_count !== 4'd3 || fetch_ready !== 1'b1)
      begin miscompares++; $display("FAIL b2b_pre got count %0d rdy %b want 3 rdy 1", ibuffer_count, fetch_ready); end
    step();
    fetch_valid = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", ibuffer_count); end
    for (int i = 1; i < 5; i++) begin
      vectors++; if (ibuffer_inst_out !== 32'hB0 + 32'(i) || ibuffer_pc_out !== 48'hB000_0000 + 48'(4 * i))
        begin miscompares++; $display("FAIL b2b_order i%0d got %h@%h want %h@%h", i, ibuffer_inst_out, ibuffer_pc_out, 32'hB0 + 32'(i), 48'hB000_0000 + 48'(4 * i)); end
      step();
    end
    dec_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive(1'b1, 2'b11, 32'hC0, 32'hC1, 48'hC000_0000, 1'b0);
    step();
    drive(1'b1, 2'b11, 32'hC2, 32'hC3, 48'hC000_0008, 1'b0);
    step();
    drive(1'b1, 2'b01, 32'hC4, 32'h0, 48'hC000_0010, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 2'b11, 32'hE0, 32'hE1, 48'hE000_0000, 1'b1);
    #1;
    vectors++; if (ibuffer_count !== 4'd5) begin miscompares++; $display("FAIL flush_pre_count got %0d want 5", ibuffer_count); end
    vectors++; if (ibuffer_instr_valid !== 1'b0 || fetch_ready !== 1'b0)
      begin miscompares++; $display("FAIL flush_cycle got v%b rdy %b want v0 rdy0", ibuffer_instr_valid, fetch_ready); end
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 48'd0, 1'b0);
    #1;
    vectors++; if (ibuffer_count !== 4'd0 || ibuffer_instr_valid !== 1'b0 || fetch_ready !== 1'b1 ||
                   ibuffer_inst_out !== 32'd0 || ibuffer_pc_out !== 48'd0)
      begin miscompares++; $display("FAIL flush_after got c%0d v%b rdy%b %h@%h want c0 v0 rdy1 0@0", ibuffer_count, ibuffer_instr_valid, fetch_ready, ibuffer_inst_out, ibuffer_pc_out); end
    drive(1'b1, 2'b01, 32'hDEAD_0001, 32'h0, 48'h8000_1000, 1'b0);
    #1;
    vectors++; if (ibuffer_instr_valid !== 1'b0) begin miscompares++; $display("FAIL flush_new_bypass got %b want 0", ibuffer_instr_valid); end
    step();
    fetch_valid = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd1 || ibuffer_inst_out !== 32'hDEAD_0001 || ibuffer_pc_out !== 48'h8000_1000)
      begin miscompares++; $display("FAIL flush_new_head got c%0d %h@%h want c1 dead0001@80001000", ibuffer_count, ibuffer_inst_out, ibuffer_pc_out); end
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
  endtask

  task automatic test_pc_wrap_and_async_reset();
    drive(1'b1, 2'b10, 32'h0, 32'h0000_0067, 48'hFFFF_FFFF_FFFC, 1'b0);
    step();
    fetch_valid = 1'b0;
    #1;
    vectors++; if (ibuffer_inst_out !== 32'h0000_0067 || ibuffer_pc_out !== 48'd0 || ibuffer_count !== 4'd1)
      begin miscompares++; $display("FAIL pc_wrap got %h@%h c%0d want 00000067@0 c1", ibuffer_inst_out, ibuffer_pc_out, ibuffer_count); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (ibuffer_count !== 4'd0 || ibuffer_instr_valid !== 1'b0 || ibuffer_pc_out !== 48'd0)
      begin miscompares++; $display("FAIL async_reset got c%0d v%b pc %h want c0 v0 pc0", ibuffer_count, ibuffer_instr_valid, ibuffer_pc_out); end
    step();
    reset_n = 1'b1;
    step();
    vectors++; if (fetch_ready !== 1'b1 || ibuffer_count !== 4'd0)
      begin miscompares++; $display("FAIL post_reset got rdy%b c%0d want rdy1 c0", fetch_ready, ibuffer_count); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_one_packet();
    test_partial();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_pc_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
